// File: rtl/tpu_tile_sequencer_if.sv
// Handshake bundle between the tile sequencer and the TPU top level.
// TILE_SEQ_STALL_CNT_EN adds the stall_count observation signal.
interface tpu_tile_sequencer_if #(
    parameter int ADDRESSSIZE = 10
);
    logic                   start;
    logic [ADDRESSSIZE-1:0] base_addr;
    logic [ADDRESSSIZE-1:0] num_rows;
    logic                   fifo_empty;
    logic                   fifo_read_enable;
    logic                   we_rl;
    logic [ADDRESSSIZE-1:0] ub_address;
    logic                   valid_address;
    logic                   addr_ctrl_en;
    logic                   result_we;
    logic [ADDRESSSIZE-1:0] result_address;
    logic                   busy;
    logic                   end_;
`ifdef TILE_SEQ_STALL_CNT_EN
    logic [15:0]            stall_count;
`endif

    modport master (
        input  start, base_addr, num_rows, fifo_empty,
        output fifo_read_enable, we_rl, ub_address, valid_address, addr_ctrl_en,
               result_we, result_address, busy, end_
`ifdef TILE_SEQ_STALL_CNT_EN
        , output stall_count
`endif
    );

    modport slave (
        output start, base_addr, num_rows, fifo_empty,
        input  fifo_read_enable, we_rl, ub_address, valid_address, addr_ctrl_en,
               result_we, result_address, busy, end_
`ifdef TILE_SEQ_STALL_CNT_EN
        , input stall_count
`endif
    );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Tile-pass sequencer: weight pop, reload pulse, row streaming, result write-back.
// Optional TILE_SEQ_STALL_CNT_EN adds a saturating FIFO-starvation cycle counter.
module tpu_tile_sequencer #(
    parameter int ADDRESSSIZE    = 10,
    parameter int RESULT_LATENCY = 17,
    parameter int PIPE_W         = 5
) (
    input logic                 clk,
    input logic                 rstn,
    tpu_tile_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, RELOAD, STREAM, DRAIN, DONE} state_t;

    state_t                    state;
    logic [ADDRESSSIZE-1:0]    base_q;
    logic [ADDRESSSIZE-1:0]    rows_left;
    logic [PIPE_W-1:0]         drain_cnt;
    logic [RESULT_LATENCY-1:0] pipe;

    // The pop follows the live empty flag so it lands in the first non-empty cycle.
    assign bus.fifo_read_enable = (state == FETCH) && !bus.fifo_empty;
    assign bus.addr_ctrl_en     = bus.valid_address;
    assign bus.result_we        = pipe[RESULT_LATENCY-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= IDLE;
            base_q             <= '0;
            rows_left          <= '0;
            drain_cnt          <= '0;
            pipe               <= '0;
            bus.we_rl          <= 1'b0;
            bus.ub_address     <= '0;
            bus.valid_address  <= 1'b0;
            bus.result_address <= '0;
            bus.busy           <= 1'b0;
            bus.end_           <= 1'b0;
        end else begin
            bus.we_rl <= 1'b0;
            bus.end_  <= 1'b0;
            pipe      <= (pipe << 1) | RESULT_LATENCY'(bus.valid_address);
            if (bus.result_we)
                bus.result_address <= bus.result_address + 1'b1;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q             <= bus.base_addr;
                        rows_left          <= bus.num_rows;
                        bus.result_address <= bus.base_addr;
                        bus.busy           <= 1'b1;
                        if (bus.num_rows == '0) begin
                            state    <= DONE;
                            bus.end_ <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (!bus.fifo_empty) begin
                        state     <= RELOAD;
                        bus.we_rl <= 1'b1;
                    end
                end
                RELOAD: begin
                    state             <= STREAM;
                    bus.ub_address    <= base_q;
                    bus.valid_address <= 1'b1;
                    rows_left         <= rows_left - 1'b1;
                end
                STREAM: begin
                    if (rows_left == '0) begin
                        // Last row is on the bus now; its write lands RESULT_LATENCY cycles later.
                        state             <= DRAIN;
                        bus.valid_address <= 1'b0;
                        drain_cnt         <= PIPE_W'(RESULT_LATENCY - 1);
                    end else begin
                        bus.ub_address <= bus.ub_address + 1'b1;
                        rows_left      <= rows_left - 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= DONE;
                        bus.end_ <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            bus.stall_count <= '0;
        else if (state == IDLE && bus.start)
            bus.stall_count <= '0;
        else if (state == FETCH && bus.fifo_empty && bus.stall_count != 16'hFFFF)
            bus.stall_count <= bus.stall_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer; cycle k counts from the edge that samples start.
// Define TILE_SEQ_STALL_CNT_EN for both RTL and bench to also cover stall_count.
module tb_tpu_tile_sequencer;
    localparam int AW  = 10;
    localparam int LAT = 17;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    tpu_tile_sequencer_if #(.ADDRESSSIZE(AW)) bus ();

    tpu_tile_sequencer #(
        .ADDRESSSIZE   (AW),
        .RESULT_LATENCY(LAT),
        .PIPE_W        (5)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] rows;
        int            stall;
        int            fre_at;
        int            we_at;
        int            ub_first;
        int            ub_last;
        int            end_at;
        int            ign1;
        int            ign2;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, k, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {5'd0, bus.fifo_read_enable, bus.we_rl, bus.ub_address, bus.valid_address,
                bus.addr_ctrl_en, bus.result_we, bus.result_address, bus.busy, bus.end_};
    endfunction

    // Entered #1 after a rising edge; returns #1 after the edge that opens cycle end_at+1.
    task automatic run_vec(input vec_t v);
        logic [AW-1:0] e_ub;
        logic [AW-1:0] e_ra;
        logic          in_ub;
        logic          in_ra;
        bus.start      = 1'b1;
        bus.base_addr  = v.base;
        bus.num_rows   = v.rows;
        bus.fifo_empty = (v.stall > 0);
        @(negedge clk);
        chk("idle_busy_before_start", 0, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.base_addr = ~v.base;
        bus.num_rows  = 10'd7;
        for (int k = 1; k <= v.end_at; k++) begin
            if (k == v.ign1 || k == v.ign2) begin
                bus.start     = 1'b1;
                bus.base_addr = 10'h300;
                bus.num_rows  = 10'd5;
            end else begin
                bus.start = 1'b0;
            end
            bus.fifo_empty = (k <= v.stall);
            @(negedge clk);
            in_ub = (k >= v.ub_first && k <= v.ub_last);
            in_ra = (k >= v.ub_first + LAT && k <= v.ub_last + LAT);
            e_ub  = v.base + AW'(k - v.ub_first);
            e_ra  = v.base + AW'(k - v.ub_first - LAT);
            chk("fifo_read_enable", k, 32'(bus.fifo_read_enable), 32'(k == v.fre_at));
            chk("we_rl", k, 32'(bus.we_rl), 32'(k == v.we_at));
            chk("valid_address", k, 32'(bus.valid_address), 32'(in_ub));
            chk("addr_ctrl_en", k, 32'(bus.addr_ctrl_en), 32'(in_ub));
            if (in_ub) chk("ub_address", k, 32'(bus.ub_address), 32'(e_ub));
            chk("result_we", k, 32'(bus.result_we), 32'(in_ra));
            if (in_ra) chk("result_address", k, 32'(bus.result_address), 32'(e_ra));
            chk("end_", k, 32'(bus.end_), 32'(k == v.end_at));
            chk("busy", k, 32'(bus.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
`ifdef TILE_SEQ_STALL_CNT_EN
        chk("stall_count", v.end_at + 1, 32'(bus.stall_count), 32'(v.stall));
`endif
    endtask

    initial begin
        int n_we;
        //            base    rows  stall fre we ub_f ub_l end ign1 ign2
        vecs[0] = '{10'h010, 10'd4, 0,    1,  2,  3,   6,  24, 0,   0};
        vecs[1] = '{10'h100, 10'd1, 5,    6,  7,  8,   8,  26, 0,   0};
        vecs[2] = '{10'h055, 10'd0, 0,    0,  0,  0,  -1,   1, 0,   0};
        vecs[3] = '{10'h3FE, 10'd3, 0,    1,  2,  3,   5,  23, 0,   0};
        vecs[4] = '{10'h040, 10'd2, 0,    1,  2,  3,   4,  22, 4,  22};
        vecs[5] = '{10'h200, 10'd1, 2,    3,  4,  5,   5,  23, 0,   0};

        rstn           = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.num_rows   = '0;
        bus.fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 0, all_outs(), 32'd0);
`ifdef TILE_SEQ_STALL_CNT_EN
        chk("reset_stall_count", 0, 32'(bus.stall_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Back-to-back: each pass starts the cycle after the previous end_.
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort two cycles into STREAM with 8 rows in flight.
        bus.start      = 1'b1;
        bus.base_addr  = 10'h020;
        bus.num_rows   = 10'd8;
        bus.fifo_empty = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_reset_valid", 5, 32'(bus.valid_address), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", 5, all_outs(), 32'd0);
`ifdef TILE_SEQ_STALL_CNT_EN
        chk("async_reset_stall_count", 5, 32'(bus.stall_count), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        n_we = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.result_we) n_we++;
        end
        chk("result_we_after_abort", 0, 32'(n_we), 32'd0);
        @(posedge clk);
        #1;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
